// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage (package fetch_pkg).
// Optional build macro: FETCH_ALIGN_CHECK_EN (misaligned redirect targets raise fetch_fault).
package fetch_pkg;

    // Controller states: normal fetching, or waiting out a wrong-path request.
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    // Flat state constants used by the state register.
    localparam logic [0:0] ST_RUN   = RUN;
    localparam logic [0:0] ST_DRAIN = DRAIN;

    // Redirect kind codes from the decoder.
    localparam logic [1:0] RK_NONE = 2'b00;
    localparam logic [1:0] RK_BR   = 2'b01;
    localparam logic [1:0] RK_J    = 2'b10;
    localparam logic [1:0] RK_JR   = 2'b11;

    // First PC fetched after reset unless overridden.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Sequential PC increment (one word).
    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of the fetch stage's memory bus and decoder handshake.
// Optional build macro: FETCH_ALIGN_CHECK_EN adds the fetch_fault signal.
interface instr_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst_out;
    logic [ADDR_W-1:0] inst_pc;

    logic              redirect;
    logic [1:0]        redirect_kind;
    logic [15:0]       br_offset;
    logic [25:0]       j_index;
    logic [ADDR_W-1:0] jr_addr;
`ifdef FETCH_ALIGN_CHECK_EN
    logic              fetch_fault;
`endif

    // Fetch stage side.
    modport master (
        output imem_req, imem_addr, inst_valid, inst_out, inst_pc,
        input  imem_ack, imem_rdata, inst_ready,
               redirect, redirect_kind, br_offset, j_index, jr_addr
`ifdef FETCH_ALIGN_CHECK_EN
        , output fetch_fault
`endif
    );

    // Memory/decoder side.
    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_out, inst_pc,
        output imem_ack, imem_rdata, inst_ready,
               redirect, redirect_kind, br_offset, j_index, jr_addr
`ifdef FETCH_ALIGN_CHECK_EN
        , input fetch_fault
`endif
    );

endinterface

// File: rtl/instr_fetch_next_pc_calc.sv
// Combinational redirect-target calculator for branch, jump and jr.
module next_pc_calc
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] inst_pc_i,
    input  logic [1:0]        redirect_kind_i,
    input  logic [15:0]       br_offset_i,
    input  logic [25:0]       j_index_i,
    input  logic [ADDR_W-1:0] jr_addr_i,
    output logic [ADDR_W-1:0] target_o
);

    logic [ADDR_W-1:0] seq_pc_s;
    logic [ADDR_W-1:0] br_disp_s;

    assign seq_pc_s  = inst_pc_i + ADDR_W'(PC_STEP);
    assign br_disp_s = {{(ADDR_W-18){br_offset_i[15]}}, br_offset_i, 2'b00};

    // Select the redirect target; branch and jump are relative to the delay-slot PC.
    always_comb begin
        target_o = seq_pc_s;
        case (redirect_kind_i)
            RK_BR:   target_o = seq_pc_s + br_disp_s;
            RK_J:    target_o = {seq_pc_s[ADDR_W-1:28], j_index_i, 2'b00};
            RK_JR:   target_o = jr_addr_i;
            default: target_o = seq_pc_s;
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, issues one outstanding memory read,
// presents instructions to the decoder and discards wrong-path data on redirects.
// Optional build macro: FETCH_ALIGN_CHECK_EN (misaligned targets halt the stage
// and raise a sticky fetch_fault; otherwise target bits [1:0] are cleared).
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic          clk,
    input  logic          reset_n,
    instr_fetch_if.master bus
);

    logic [0:0]        state_q,      state_d;
    logic [ADDR_W-1:0] fetch_pc_q,   fetch_pc_d;
    logic [ADDR_W-1:0] target_q,     target_d;
    logic              inst_valid_q, inst_valid_d;
    logic [31:0]       inst_out_q,   inst_out_d;
    logic [ADDR_W-1:0] inst_pc_q,    inst_pc_d;
    logic              pending_q,    pending_d;
    logic              run_q;
    logic              halt_s;

    logic              slot_free_s;
    logic              accept_s;
    logic              redir_s;
    logic              req_s;
    logic [ADDR_W-1:0] target_s;
    logic [ADDR_W-1:0] target_fix_s;

    assign slot_free_s = !inst_valid_q || bus.inst_ready;
    assign accept_s    = inst_valid_q && bus.inst_ready;
    assign redir_s     = accept_s && bus.redirect && (bus.redirect_kind != RK_NONE);

    next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc_calc (
        .inst_pc_i       (inst_pc_q),
        .redirect_kind_i (bus.redirect_kind),
        .br_offset_i     (bus.br_offset),
        .j_index_i       (bus.j_index),
        .jr_addr_i       (bus.jr_addr),
        .target_o        (target_s)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q;
    logic fault_d;
    assign target_fix_s    = target_s;
    assign fault_d         = fault_q || (redir_s && (target_s[1:0] != 2'b00));
    assign halt_s          = fault_q;
    assign bus.fetch_fault = fault_q;

    // Sticky misalignment fault, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    assign target_fix_s = target_s & {{(ADDR_W-2){1'b1}}, 2'b00};
    assign halt_s       = 1'b0;
`endif

    // Request generation: a held request stays up until acked; DRAIN always finishes.
    always_comb begin
        if (!run_q) begin
            req_s = 1'b0;
        end else if (state_q == ST_DRAIN) begin
            req_s = 1'b1;
        end else if (halt_s) begin
            req_s = 1'b0;
        end else begin
            req_s = slot_free_s || pending_q;
        end
    end

    // Next-state logic for the PC, output slot and drain controller.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        target_d     = target_q;
        inst_valid_d = inst_valid_q;
        inst_out_d   = inst_out_q;
        inst_pc_d    = inst_pc_q;
        pending_d    = pending_q;
        case (state_q)
            ST_RUN: begin
                if (redir_s) begin
                    inst_valid_d = 1'b0;
                    if (req_s && !bus.imem_ack) begin
                        state_d   = ST_DRAIN;
                        target_d  = target_fix_s;
                        pending_d = 1'b1;
                    end else begin
                        fetch_pc_d = target_fix_s;
                        pending_d  = 1'b0;
                    end
                end else if (req_s && bus.imem_ack) begin
                    inst_out_d   = bus.imem_rdata;
                    inst_pc_d    = fetch_pc_q;
                    inst_valid_d = 1'b1;
                    fetch_pc_d   = fetch_pc_q + ADDR_W'(PC_STEP);
                    pending_d    = 1'b0;
                end else begin
                    if (accept_s) begin
                        inst_valid_d = 1'b0;
                    end else begin
                        inst_valid_d = inst_valid_q;
                    end
                    pending_d = req_s;
                end
            end
            ST_DRAIN: begin
                inst_valid_d = 1'b0;
                if (bus.imem_ack) begin
                    state_d    = ST_RUN;
                    fetch_pc_d = target_q;
                    pending_d  = 1'b0;
                end else begin
                    pending_d = 1'b1;
                end
            end
            default: begin
                state_d      = ST_RUN;
                inst_valid_d = 1'b0;
                pending_d    = 1'b0;
            end
        endcase
    end

    // Run enable: keeps the memory request low until the first cycle after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RUN;
            fetch_pc_q   <= RESET_PC;
            target_q     <= {ADDR_W{1'b0}};
            inst_valid_q <= 1'b0;
            inst_out_q   <= 32'h0000_0000;
            inst_pc_q    <= {ADDR_W{1'b0}};
            pending_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            target_q     <= target_d;
            inst_valid_q <= inst_valid_d;
            inst_out_q   <= inst_out_d;
            inst_pc_q    <= inst_pc_d;
            pending_q    <= pending_d;
        end
    end

    assign bus.imem_req   = req_s;
    assign bus.imem_addr  = fetch_pc_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst_out   = inst_out_q;
    assign bus.inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a scoreboard of expected instructions.
// Honors FETCH_ALIGN_CHECK_EN for the misaligned-jr scenario.
module tb_instr_fetch;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic zw;
    logic ack_man;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    instr_fetch_if #(.ADDR_W(32)) bus ();

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_5AA5;
    endfunction

    assign bus.imem_ack   = zw ? bus.imem_req : ack_man;
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        sb.push_back({pc, mem_word(pc)});
    endtask

    task automatic expect_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_valid"}, {31'd0, bus.inst_valid}, 32'd1);
            check({tag, "_pc"},    bus.inst_pc,  e.pc);
            check({tag, "_data"},  bus.inst_out, e.data);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n           = 1'b0;
        zw                = 1'b1;
        ack_man           = 1'b0;
        bus.inst_ready    = 1'b1;
        bus.redirect      = 1'b0;
        bus.redirect_kind = 2'b00;
        bus.br_offset     = 16'h0000;
        bus.j_index       = 26'h0;
        bus.jr_addr       = 32'h0;

        // Reset state
        tick();
        tick();
        check("rst_req",   {31'd0, bus.imem_req},   32'd0);
        check("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("rst_pc",    bus.inst_pc,  32'h0);
        check("rst_out",   bus.inst_out, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        check("rst_fault", {31'd0, bus.fetch_fault}, 32'd0);
`endif
        reset_n = 1'b1;
        tick();
        check("first_req",  {31'd0, bus.imem_req}, 32'd1);
        check("first_addr", bus.imem_addr, 32'h0);

        // Zero-wait stream
        push_exp(32'h0);
        push_exp(32'h4);
        push_exp(32'h8);
        push_exp(32'hC);
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_out("stream");
        end
        tick();

        // Backpressure on pc 0xC
        bus.inst_ready = 1'b0;
        #1;
        check("bp_req0", {31'd0, bus.imem_req}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_req",   {31'd0, bus.imem_req}, 32'd0);
            check("bp_valid", {31'd0, bus.inst_valid}, 32'd1);
            check("bp_pc",    bus.inst_pc,  32'hC);
            check("bp_out",   bus.inst_out, mem_word(32'hC));
        end
        bus.inst_ready = 1'b1;
        #1;
        check("bp_rel_req",  {31'd0, bus.imem_req}, 32'd1);
        check("bp_rel_addr", bus.imem_addr, 32'h10);
        expect_out("bp_rel");

        // Branch back by two words from pc 0x10
        push_exp(32'h10);
        tick();
        expect_out("pre_br");
        bus.redirect      = 1'b1;
        bus.redirect_kind = 2'b01;
        bus.br_offset     = 16'hFFFE;
        #1;
        check("br_wp_addr", bus.imem_addr, 32'h14);
        tick();
        bus.redirect      = 1'b0;
        bus.redirect_kind = 2'b00;
        #1;
        check("br_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("br_req",   {31'd0, bus.imem_req}, 32'd1);
        check("br_addr",  bus.imem_addr, 32'hC);
        push_exp(32'hC);
        tick();
        expect_out("br_tgt");

        // jr to 0x4000_0010 to set up the jump test
        bus.redirect      = 1'b1;
        bus.redirect_kind = 2'b11;
        bus.jr_addr       = 32'h4000_0010;
        tick();
        bus.redirect      = 1'b0;
        bus.redirect_kind = 2'b00;
        push_exp(32'h4000_0010);
        tick();
        expect_out("jr_land");

        // Jump with slow memory: request for 0x4000_0014 is in flight
        zw                = 1'b0;
        ack_man           = 1'b0;
        bus.redirect      = 1'b1;
        bus.redirect_kind = 2'b10;
        bus.j_index       = 26'h100;
        #1;
        check("j_wp_addr", bus.imem_addr, 32'h4000_0014);
        tick();
        bus.redirect      = 1'b0;
        bus.redirect_kind = 2'b00;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("drain_req",   {31'd0, bus.imem_req}, 32'd1);
            check("drain_addr",  bus.imem_addr, 32'h4000_0014);
            check("drain_valid", {31'd0, bus.inst_valid}, 32'd0);
            if (k == 0) tick();
        end
        ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        #1;
        check("j_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("j_req",   {31'd0, bus.imem_req}, 32'd1);
        check("j_addr",  bus.imem_addr, 32'h4000_0400);
        push_exp(32'h4000_0400);
        ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        expect_out("j_tgt");

        // Wrap from 0xFFFF_FFFC to 0
        zw                = 1'b1;
        bus.redirect      = 1'b1;
        bus.redirect_kind = 2'b11;
        bus.jr_addr       = 32'hFFFF_FFFC;
        tick();
        bus.redirect      = 1'b0;
        bus.redirect_kind = 2'b00;
        push_exp(32'hFFFF_FFFC);
        push_exp(32'h0000_0000);
        tick();
        expect_out("wrap_hi");
        tick();
        expect_out("wrap_lo");

        // Misaligned jr to 0x102
        bus.redirect      = 1'b1;
        bus.redirect_kind = 2'b11;
        bus.jr_addr       = 32'h0000_0102;
        tick();
        bus.redirect      = 1'b0;
        bus.redirect_kind = 2'b00;
        #1;
`ifdef FETCH_ALIGN_CHECK_EN
        check("mis_fault", {31'd0, bus.fetch_fault}, 32'd1);
        check("mis_req",   {31'd0, bus.imem_req}, 32'd0);
        check("mis_valid", {31'd0, bus.inst_valid}, 32'd0);
        tick();
        tick();
        check("mis_req_hold",   {31'd0, bus.imem_req}, 32'd0);
        check("mis_fault_hold", {31'd0, bus.fetch_fault}, 32'd1);
`else
        check("mis_req",   {31'd0, bus.imem_req}, 32'd1);
        check("mis_addr",  bus.imem_addr, 32'h0000_0100);
        check("mis_valid", {31'd0, bus.inst_valid}, 32'd0);
        push_exp(32'h0000_0100);
        tick();
        expect_out("mis_land");
        zw      = 1'b0;
        ack_man = 1'b0;
        #1;
        check("mid_req", {31'd0, bus.imem_req}, 32'd1);
`endif

        // Reset in the middle of activity; stray ack during reset is ignored
        reset_n = 1'b0;
        zw      = 1'b0;
        ack_man = 1'b1;
        #1;
        check("rst2_req",   {31'd0, bus.imem_req},   32'd0);
        check("rst2_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("rst2_pc",    bus.inst_pc, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        check("rst2_fault", {31'd0, bus.fetch_fault}, 32'd0);
`endif
        tick();
        check("rst2_valid_hold", {31'd0, bus.inst_valid}, 32'd0);
        ack_man = 1'b0;
        zw      = 1'b1;
        reset_n = 1'b1;
        tick();
        check("rst2_req_up", {31'd0, bus.imem_req}, 32'd1);
        check("rst2_addr",   bus.imem_addr, 32'h0);
        check("sb_empty",    sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage directly upstream of the CPU's decoder.
- Owns the program counter and issues word reads to instruction memory over a req/ack handshake.
- Presents each fetched instruction and its PC to the decoder over a valid/ready handshake.
- Applies branch, jump and jump-register redirects. At most one memory request is outstanding, and wrong-path data is discarded.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset; must be word-aligned.
- ADDR_W, 32, PC and memory address width.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  reset, asynchronous and active-low.
- imem_req  out  1  request to instruction memory.
- imem_addr  out  ADDR_W  word address of the request.
- imem_ack  in  1  request complete; imem_rdata valid this cycle (may arrive in the same cycle as imem_req).
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  inst_out/inst_pc hold a valid instruction.
- inst_ready  in  1  decoder accepts the instruction this cycle.
- inst_out  out  32  instruction to the decoder.
- inst_pc  out  ADDR_W  PC of inst_out.
- redirect  in  1  the instruction being accepted changes flow; sampled only when inst_valid & inst_ready.
- redirect_kind  in  2  01 = branch, 10 = jump, 11 = jr; 00 is ignored.
- br_offset  in  16  branch immediate (word offset).
- j_index  in  26  jump index.
- jr_addr  in  ADDR_W  register target for jr.
- fetch_fault  out  1  misaligned redirect target; exists only with the optional feature.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - fetch_pc=RESET_PC, state=RUN, inst_valid=0, inst_out=0, inst_pc=0, imem_req=0, fetch_fault=0.
  - imem_req first rises in the first cycle after reset_n rises.
- Output slot is one register.
  - slot_free = !inst_valid | inst_ready.
- States: RUN, DRAIN.
- RUN:
  - imem_req = slot_free | req_pending. req_pending is set when a request was raised and not yet acked.
  - A new request starts only when slot_free; once raised, imem_req and imem_addr stay stable until imem_ack.
  - On imem_ack with no redirect: inst_out<=imem_rdata, inst_pc<=fetch_pc, inst_valid<=1, fetch_pc<=fetch_pc+4.
  - Zero-wait memory with inst_ready held at 1 gives 1 instruction per cycle.
- Consumption: inst_valid & inst_ready with no ack loaded clears inst_valid at the edge.
- Redirect (accepted with inst_valid & inst_ready & redirect & redirect_kind!=00):
  - Branch target = inst_pc + 4 + (sign-extend(br_offset) << 2), modulo 2^32.
  - Jump target = {inst_pc+4 [31:28], j_index, 2'b00}.
  - jr target = jr_addr.
  - fetch_pc <= target.
  - If imem_ack is in the same cycle, that data is dropped and inst_valid <= 0.
  - If a request is in flight without ack, go to DRAIN.
- DRAIN:
  - imem_req stays high with the old address; inst_valid=0.
  - On ack, discard the data and return to RUN; the next request uses the target.
  - A redirect cannot arrive in DRAIN because inst_valid=0.
- Redirect and consumption in the same cycle: the redirect wins, and no wrong-path instruction is ever presented.
- Backpressure: while inst_valid & !inst_ready, no new request; inst_out and inst_pc hold stable.
- Wrap: fetch_pc+4 wraps from 32'hFFFF_FFFC to 0 silently.
- Reset mid-request: state is cleared immediately; any in-flight ack after reset is ignored because imem_req=0 during reset.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - A redirect target with [1:0]!=0 sets fetch_fault=1 (sticky until reset).
  - imem_req is forced to 0 and inst_valid to 0; a pending DRAIN completes first, then the stage stops.
- Undefined:
  - fetch_fault is absent and the target bits [1:0] are forced to 00.

Decomposition:
- Package fetch_pkg holds:
  - state enum {RUN, DRAIN};
  - redirect_kind codes RK_NONE, RK_BR, RK_J, RK_JR;
  - the default RESET_PC;
  - the constant PC_STEP=4.
- One combinational sub-module, next_pc_calc: inputs inst_pc, redirect_kind, br_offset, j_index, jr_addr; output target.

Test Plan:
- Reset: hold reset_n=0 with RESET_PC=0 -> imem_req=0, inst_valid=0. Release -> next cycle imem_req=1, imem_addr=0.
- Zero-wait stream: imem_ack tied to imem_req, inst_ready=1 -> inst_pc 0,4,8,12 on consecutive cycles, inst_out equals memory contents.
- Backpressure: inst_ready=0 for 3 cycles while inst_valid=1 -> imem_req=0, inst_out and inst_pc unchanged. ready=1 -> request for the next PC in the same cycle.
- Branch: accept inst_pc=0x10, kind=01, br_offset=0xFFFE, zero-wait memory -> 0x14 data dropped, next imem_addr=0x0C, next inst_pc=0x0C.
- Jump with slow memory (ack 2 cycles late): inst_pc=0x4000_0010, j_index=0x100 -> DRAIN holds addr 0x14 until ack, data discarded, then imem_addr=0x4000_0400.
- jr to 0x102: with FETCH_ALIGN_CHECK_EN -> fetch_fault=1, imem_req=0 thereafter. Without it -> imem_addr=0x100.
